cpu_dma_ctrl: RTL

Parametrised multi-channel sprite/memory DMA engine for the NES CPU core, generalising the single hard-wired $4014 OAM DMA. Each channel is triggered by a CPU write to its trigger address and copies LEN bytes from a source page to a fixed destination port. Copies are done as alternating read/write bus cycles, while the CPU is halted through a request/acknowledge handshake. It sits between the CPU datapath and the external bus mux, and owns the bus only while `bus_own` is high.

---
 rtl/cpu_dma_pkg.sv | 21 ++
 rtl/cpu_dma_ctrl_if.sv | 30 +++
 rtl/cpu_dma_arb.sv | 24 ++
 rtl/cpu_dma_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cpu_dma_pkg.sv
// Shared state encoding, default addresses and sizing helper for the CPU DMA engine.
package cpu_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    localparam logic [15:0] DEF_TRIG_BASE = 16'h4014;
    localparam logic [15:0] DEF_DEST_ADDR = 16'h2004;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_dma_ctrl_if.sv
// CPU-side trigger/halt signals and DMA bus signals of cpu_dma_ctrl.
// master = the DMA engine, slave = the CPU/bus environment around it.
interface cpu_dma_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              halt_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              halt_req;
    logic              bus_own;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_r_bw;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_we, halt_ack, bus_rdata,
        output halt_req, bus_own, bus_addr, bus_wdata, bus_r_bw, busy, done
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_we, halt_ack, bus_rdata,
        input  halt_req, bus_own, bus_addr, bus_wdata, bus_r_bw, busy, done
    );
endinterface

// File: rtl/cpu_dma_arb.sv
// Fixed-priority picker: lowest-index requester wins; purely combinational.
module cpu_dma_arb
    import cpu_dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    output logic              vld,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_dma_ctrl.sv
// Multi-channel page-to-port DMA: halts the CPU, then alternates read/write bus cycles.
// Trigger-to-HALT is one cycle; READs are kept on even cyc_par, inserting one ALIGN read if needed.
module cpu_dma_ctrl
    import cpu_dma_pkg::*;
#(
    parameter int              NUM_CH    = 2,
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 8,
    parameter int              LEN       = 256,
    parameter logic [ADDR_W-1:0] TRIG_BASE = ADDR_W'(DEF_TRIG_BASE),
    parameter logic [ADDR_W-1:0] DEST_ADDR = ADDR_W'(DEF_DEST_ADDR)
) (
    input logic            clk,
    input logic            rst,
    cpu_dma_ctrl_if.master bus
);

    localparam int                CH_W = idx_w(NUM_CH);
    localparam logic [DATA_W-1:0] LAST = DATA_W'(LEN - 1);

    dma_state_t        state, state_nxt;
    logic [NUM_CH-1:0] pend, pend_nxt, trig_ok, arb_req;
    logic [DATA_W-1:0] page [NUM_CH];
    logic [DATA_W-1:0] offset, data_buf, wdata_q;
    logic [ADDR_W-1:0] addr_q, rd_addr;
    logic [CH_W-1:0]   act_ch, arb_idx;
    logic              arb_vld, cyc_par;

    // A trigger for the channel currently being served is dropped.
    always_comb begin
        trig_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.cpu_we && bus.cpu_addr == TRIG_BASE + ADDR_W'(c)
                && !(state != IDLE && act_ch == CH_W'(c)))
                trig_ok[c] = 1'b1;
        end
    end

    // Same-cycle triggers take part in arbitration so HALT follows the write immediately.
    assign arb_req = pend | trig_ok;
    assign rd_addr = ADDR_W'({page[act_ch], offset});

    cpu_dma_arb #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_arb (
        .req (arb_req),
        .vld (arb_vld),
        .idx (arb_idx)
    );

    always_comb begin
        pend_nxt = arb_req;
        if (state == IDLE && arb_vld)
            pend_nxt[arb_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = HALT;
            HALT:    if (bus.halt_ack) state_nxt = cyc_par ? READ : ALIGN;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (offset == LAST) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.halt_req  = 1'b0;
        bus.bus_own   = 1'b0;
        bus.bus_r_bw  = 1'b1;
        bus.bus_addr  = addr_q;
        bus.bus_wdata = wdata_q;
        bus.done      = '0;
        bus.busy      = pend;
        if (state != IDLE)
            bus.busy[act_ch] = 1'b1;
        case (state)
            HALT: bus.halt_req = 1'b1;
            ALIGN, READ: begin
                bus.halt_req = 1'b1;
                bus.bus_own  = 1'b1;
                bus.bus_addr = rd_addr;
            end
            WRITE: begin
                bus.halt_req  = 1'b1;
                bus.bus_own   = 1'b1;
                bus.bus_r_bw  = 1'b0;
                bus.bus_addr  = DEST_ADDR;
                bus.bus_wdata = data_buf;
            end
            DONE:    bus.done[act_ch] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            offset   <= '0;
            act_ch   <= '0;
            cyc_par  <= 1'b0;
            data_buf <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            for (int c = 0; c < NUM_CH; c++)
                page[c] <= '0;
        end else begin
            cyc_par <= ~cyc_par;
            pend    <= pend_nxt;
            for (int c = 0; c < NUM_CH; c++)
                if (trig_ok[c]) page[c] <= bus.cpu_wdata;
            if (state == IDLE && arb_vld)
                act_ch <= arb_idx;
            if (state == READ)
                data_buf <= bus.bus_rdata;
            if (state == WRITE && offset != LAST)
                offset <= offset + DATA_W'(1);
            if (state == DONE)
                offset <= '0;
            // Held copies let the bus keep its last address/data while released.
            if (bus.bus_own)
                addr_q <= bus.bus_addr;
            if (state == WRITE)
                wdata_q <= bus.bus_wdata;
        end
    end

endmodule
